// File: rtl/exec_pkg.sv
// Shared encodings for the EX stage: ALU ops, mul/div ops, forward selects and mul/div FSM states.
package exec_pkg;

    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned MDOP_W  = 2;
    localparam int unsigned FWD_W   = 2;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd11;
    localparam logic [ALUOP_W-1:0] ALU_MFHI = 4'd12;
    localparam logic [ALUOP_W-1:0] ALU_MFLO = 4'd13;

    localparam logic [MDOP_W-1:0] MD_NONE   = 2'b00;
    localparam logic [MDOP_W-1:0] MD_MULTU  = 2'b01;
    localparam logic [MDOP_W-1:0] MD_DIVU   = 2'b10;
    localparam logic [MDOP_W-1:0] MD_IGNORE = 2'b11;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle, with HI/LO.
module muldiv_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MDOP_W-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES);

    md_state_t          state;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    // acc: partial high product / remainder; shreg: multiplier->low product / dividend->quotient
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   shreg_nxt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // One iteration of whichever operation is in flight
    always_comb begin
        sum       = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        shifted   = {acc, shreg[WIDTH-1]};
        diff      = shifted - {1'b0, opnd};
        acc_nxt   = sum[WIDTH:1];
        shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
        if (is_div) begin
            acc_nxt   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            shreg_nxt = {shreg[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            count  <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            shreg  <= '0;
            opnd   <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start && (op == MD_MULTU || op == MD_DIVU)) begin
                        state  <= MD_BUSY;
                        busy   <= 1'b1;
                        count  <= '0;
                        is_div <= (op == MD_DIVU);
                        acc    <= '0;
                        shreg  <= a;
                        opnd   <= b;
                    end
                end
                MD_BUSY: begin
                    acc   <= acc_nxt;
                    shreg <= shreg_nxt;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(MULDIV_CYCLES - 1)) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                        hi    <= acc_nxt;
                        lo    <= shreg_nxt;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, ALU, mul/div unit hookup, stall generation and the EX/MEM register.
module execute_stage
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FWD_W-1:0]   ForwardA,
    input  logic [FWD_W-1:0]   ForwardB,
    input  logic [FWD_W-1:0]   ForwardM,
    input  logic               ex_valid,
    input  logic [WIDTH-1:0]   ex_rs_data,
    input  logic [WIDTH-1:0]   ex_rt_data,
    input  logic [WIDTH-1:0]   ex_imm,
    input  logic [4:0]         ex_shamt,
    input  logic               ex_alusrc1,
    input  logic               ex_alusrc2,
    input  logic [ALUOP_W-1:0] ex_aluop,
    input  logic [MDOP_W-1:0]  ex_muldiv_op,
    input  logic [4:0]         ex_write_addr,
    input  logic               ex_regwrite,
    input  logic               ex_memread,
    input  logic               ex_memwrite,
    input  logic [WIDTH-1:0]   mem_fwd_data,
    input  logic [WIDTH-1:0]   wb_fwd_data,
    output logic               ex_stall,
    output logic               muldiv_busy,
    output logic               mem_valid,
    output logic               mem_regwrite,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic [WIDTH-1:0]   mem_alu_result,
    output logic [WIDTH-1:0]   mem_store_data,
    output logic [4:0]         mem_write_addr,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    function automatic logic [WIDTH-1:0] fwd_mux(input logic [FWD_W-1:0] sel,
                                                 input logic [WIDTH-1:0] reg_v,
                                                 input logic [WIDTH-1:0] mem_v,
                                                 input logic [WIDTH-1:0] wb_v);
        case (sel)
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            FWD_REG: return reg_v;
            default: return reg_v;
        endcase
    endfunction

    logic [WIDTH-1:0] rs_fwd;
    logic [WIDTH-1:0] rt_fwd;
    logic [WIDTH-1:0] store_fwd;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] alu_result;
    logic             md_req;
    logic             md_start;

    assign rs_fwd    = fwd_mux(ForwardA, ex_rs_data, mem_fwd_data, wb_fwd_data);
    assign rt_fwd    = fwd_mux(ForwardB, ex_rt_data, mem_fwd_data, wb_fwd_data);
    assign store_fwd = fwd_mux(ForwardM, ex_rt_data, mem_fwd_data, wb_fwd_data);
    assign a_op      = ex_alusrc1 ? WIDTH'(ex_shamt) : rs_fwd;
    assign b_op      = ex_alusrc2 ? ex_imm : rt_fwd;

    // Only instructions that touch HI/LO or the unit wait for it; everything else flows past
    assign md_req   = (ex_muldiv_op != MD_NONE) && (ex_muldiv_op != MD_IGNORE);
    assign ex_stall = muldiv_busy && ex_valid &&
                      (ex_aluop == ALU_MFHI || ex_aluop == ALU_MFLO || md_req);
    assign md_start = ex_valid && !ex_stall && md_req;

    always_comb begin
        alu_result = '0;
        case (ex_aluop)
            ALU_ADD:  alu_result = a_op + b_op;
            ALU_SUB:  alu_result = a_op - b_op;
            ALU_AND:  alu_result = a_op & b_op;
            ALU_OR:   alu_result = a_op | b_op;
            ALU_XOR:  alu_result = a_op ^ b_op;
            ALU_NOR:  alu_result = ~(a_op | b_op);
            ALU_SLT:  alu_result = WIDTH'($signed(a_op) < $signed(b_op));
            ALU_SLTU: alu_result = WIDTH'(a_op < b_op);
            ALU_SLL:  alu_result = b_op << a_op[4:0];
            ALU_SRL:  alu_result = b_op >> a_op[4:0];
            ALU_SRA:  alu_result = WIDTH'($signed(b_op) >>> a_op[4:0]);
            ALU_LUI:  alu_result = WIDTH'({b_op[15:0], 16'b0});
            ALU_MFHI: alu_result = hi;
            ALU_MFLO: alu_result = lo;
            default:  alu_result = '0;
        endcase
    end

    muldiv_unit #(
        .WIDTH         (WIDTH),
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (reset),
        .start (md_start),
        .op    (ex_muldiv_op),
        .a     (rs_fwd),
        .b     (rt_fwd),
        .busy  (muldiv_busy),
        .hi    (hi),
        .lo    (lo)
    );

    // EX/MEM register; bubbles clear control only, data fields hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid      <= 1'b0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_write_addr <= '0;
        end else if (ex_stall || !ex_valid) begin
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
        end else begin
            mem_valid      <= 1'b1;
            mem_regwrite   <= ex_regwrite;
            mem_memread    <= ex_memread;
            mem_memwrite   <= ex_memwrite;
            mem_alu_result <= alu_result;
            mem_store_data <= store_fwd;
            mem_write_addr <= ex_write_addr;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU/forwarding vector table plus mul/div, stall and reset sequences.
module tb_execute_stage;
    import exec_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   ForwardA, ForwardB, ForwardM;
    logic         ex_valid;
    logic [W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]   ex_shamt;
    logic         ex_alusrc1, ex_alusrc2;
    logic [3:0]   ex_aluop;
    logic [1:0]   ex_muldiv_op;
    logic [4:0]   ex_write_addr;
    logic         ex_regwrite, ex_memread, ex_memwrite;
    logic [W-1:0] mem_fwd_data, wb_fwd_data;
    logic         ex_stall, muldiv_busy;
    logic         mem_valid, mem_regwrite, mem_memread, mem_memwrite;
    logic [W-1:0] mem_alu_result, mem_store_data;
    logic [4:0]   mem_write_addr;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.WIDTH(W), .MULDIV_CYCLES(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB),
        .ForwardM       (ForwardM),
        .ex_valid       (ex_valid),
        .ex_rs_data     (ex_rs_data),
        .ex_rt_data     (ex_rt_data),
        .ex_imm         (ex_imm),
        .ex_shamt       (ex_shamt),
        .ex_alusrc1     (ex_alusrc1),
        .ex_alusrc2     (ex_alusrc2),
        .ex_aluop       (ex_aluop),
        .ex_muldiv_op   (ex_muldiv_op),
        .ex_write_addr  (ex_write_addr),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .mem_fwd_data   (mem_fwd_data),
        .wb_fwd_data    (wb_fwd_data),
        .ex_stall       (ex_stall),
        .muldiv_busy    (muldiv_busy),
        .mem_valid      (mem_valid),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_write_addr (mem_write_addr),
        .hi             (hi),
        .lo             (lo)
    );

    typedef struct {
        string      name;
        logic [1:0] fa, fb, fm;
        logic [W-1:0] rs, rt, imm, memf, wbf;
        logic [4:0] shamt;
        logic       src1, src2, memwrite;
        logic [3:0] op;
        logic [W-1:0] exp_res, exp_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [1:0] fa, fb, fm,
                                input logic [W-1:0] rs, rt, imm, memf, wbf,
                                input logic [4:0] shamt, input logic src1, src2, memwrite,
                                input logic [3:0] op, input logic [W-1:0] exp_res, exp_st);
        vec_t v;
        v.name = name; v.fa = fa; v.fb = fb; v.fm = fm;
        v.rs = rs; v.rt = rt; v.imm = imm; v.memf = memf; v.wbf = wbf;
        v.shamt = shamt; v.src1 = src1; v.src2 = src2; v.memwrite = memwrite;
        v.op = op; v.exp_res = exp_res; v.exp_st = exp_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ForwardA = 2'b00; ForwardB = 2'b00; ForwardM = 2'b00;
        ex_valid = 1'b0; ex_shamt = 5'd0; ex_alusrc1 = 1'b0; ex_alusrc2 = 1'b0;
        ex_aluop = 4'd0; ex_muldiv_op = 2'b00; ex_write_addr = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    endtask

    task automatic issue_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        idle_inputs();
        ex_valid = 1'b1; ex_muldiv_op = op; ex_rs_data = a; ex_rt_data = b;
    endtask

    task automatic issue_alu(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] imm);
        idle_inputs();
        ex_valid = 1'b1; ex_aluop = op; ex_rs_data = rs; ex_imm = imm;
        ex_alusrc2 = 1'b1; ex_regwrite = 1'b1; ex_write_addr = 5'd9;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the unit to finish; n is the number of edges waited
    task automatic wait_idle(output int n);
        n = 0;
        while (muldiv_busy && n < 40) begin
            tick();
            n++;
        end
        chk("busy_timeout", W'(muldiv_busy), '0);
    endtask

    initial begin
        int n, stall_cnt, bubble_cnt, busy_cnt;

        idle_inputs();
        ex_rs_data = '0; ex_rt_data = '0; ex_imm = '0;
        mem_fwd_data = '0; wb_fwd_data = '0;
        reset = 1'b0;
        #3;
        chk("rst_mem_valid", W'(mem_valid), '0);
        chk("rst_busy", W'(muldiv_busy), '0);
        chk("rst_result", mem_alu_result, '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        tick();
        reset = 1'b1;

        vecs.push_back(mk("fwdA_mem", 2'b10, 2'b00, 2'b00, 32'd1, 32'h55, 32'd10, 32'd2, 32'd3, 5'd0, 0, 1, 0, ALU_ADD, 32'd12, 32'h55));
        vecs.push_back(mk("fwdA_wb", 2'b01, 2'b00, 2'b00, 32'd1, 32'h55, 32'd10, 32'd2, 32'd3, 5'd0, 0, 1, 0, ALU_ADD, 32'd13, 32'h55));
        vecs.push_back(mk("fwdA_11", 2'b11, 2'b00, 2'b00, 32'd1, 32'h55, 32'd10, 32'd2, 32'd3, 5'd0, 0, 1, 0, ALU_ADD, 32'd11, 32'h55));
        vecs.push_back(mk("store_fwd", 2'b00, 2'b10, 2'b01, 32'h1000, 32'h11, 32'h40, 32'h22, 32'hDEADBEEF, 5'd0, 0, 1, 1, ALU_ADD, 32'h1040, 32'hDEADBEEF));
        vecs.push_back(mk("sub", 2'b00, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_SUB, 32'hFFFFFFFE, 32'd7));
        vecs.push_back(mk("and", 2'b00, 2'b00, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_AND, 32'hF000F000, 32'hFF00FF00));
        vecs.push_back(mk("or", 2'b00, 2'b00, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_OR, 32'hFFF0FFF0, 32'hFF00FF00));
        vecs.push_back(mk("xor", 2'b00, 2'b00, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_XOR, 32'h0FF00FF0, 32'hFF00FF00));
        vecs.push_back(mk("nor", 2'b00, 2'b00, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_NOR, 32'h000F000F, 32'hFF00FF00));
        vecs.push_back(mk("slt", 2'b00, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_SLT, 32'd1, 32'd1));
        vecs.push_back(mk("sltu", 2'b00, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_SLTU, 32'd0, 32'd1));
        vecs.push_back(mk("sll", 2'b00, 2'b00, 2'b00, 32'd0, 32'hF, 32'd0, 32'd0, 32'd0, 5'd4, 1, 0, 0, ALU_SLL, 32'hF0, 32'hF));
        vecs.push_back(mk("srl", 2'b00, 2'b00, 2'b00, 32'd0, 32'h80000000, 32'd0, 32'd0, 32'd0, 5'd4, 1, 0, 0, ALU_SRL, 32'h08000000, 32'h80000000));
        vecs.push_back(mk("sra", 2'b00, 2'b00, 2'b00, 32'd0, 32'h80000000, 32'd0, 32'd0, 32'd0, 5'd4, 1, 0, 0, ALU_SRA, 32'hF8000000, 32'h80000000));
        vecs.push_back(mk("srlv", 2'b00, 2'b00, 2'b00, 32'h23, 32'h80000000, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ALU_SRL, 32'h10000000, 32'h80000000));
        vecs.push_back(mk("lui", 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'h00001234, 32'd0, 32'd0, 5'd0, 0, 1, 0, ALU_LUI, 32'h12340000, 32'd0));
        vecs.push_back(mk("op14", 2'b00, 2'b00, 2'b00, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 4'd14, 32'd0, 32'd6));
        vecs.push_back(mk("fwdB_mem", 2'b00, 2'b10, 2'b00, 32'd1, 32'd7, 32'd0, 32'h100, 32'd0, 5'd0, 0, 0, 0, ALU_ADD, 32'h101, 32'd7));
        vecs.push_back(mk("add_wrap", 2'b00, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd2, 32'd0, 32'd0, 5'd0, 0, 1, 0, ALU_ADD, 32'd1, 32'd0));

        foreach (vecs[i]) begin
            idle_inputs();
            ex_valid = 1'b1; ex_regwrite = 1'b1; ex_write_addr = 5'(i);
            ForwardA = vecs[i].fa; ForwardB = vecs[i].fb; ForwardM = vecs[i].fm;
            ex_rs_data = vecs[i].rs; ex_rt_data = vecs[i].rt; ex_imm = vecs[i].imm;
            mem_fwd_data = vecs[i].memf; wb_fwd_data = vecs[i].wbf;
            ex_shamt = vecs[i].shamt; ex_alusrc1 = vecs[i].src1; ex_alusrc2 = vecs[i].src2;
            ex_memwrite = vecs[i].memwrite; ex_aluop = vecs[i].op;
            tick();
            chk({vecs[i].name, "_result"}, mem_alu_result, vecs[i].exp_res);
            chk({vecs[i].name, "_store"}, mem_store_data, vecs[i].exp_st);
            chk({vecs[i].name, "_valid"}, W'(mem_valid), W'(1));
            chk({vecs[i].name, "_waddr"}, W'(mem_write_addr), W'(i));
        end

        // Bubble: control clears, data holds
        idle_inputs();
        tick();
        chk("bubble_valid", W'(mem_valid), '0);
        chk("bubble_regwrite", W'(mem_regwrite), '0);
        chk("bubble_data_hold", mem_alu_result, 32'd1);

        // Muldiv op 11 is ignored
        issue_md(2'b11, 32'd3, 32'd4);
        tick();
        chk("op11_busy", W'(muldiv_busy), '0);

        // MULTU, then an unrelated ADD, then a stalled MFHI
        issue_md(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        tick();
        busy_cnt = muldiv_busy ? 1 : 0;
        issue_alu(ALU_ADD, 32'd3, 32'd4);
        #1;
        chk("add_no_stall", W'(ex_stall), '0);
        tick();
        if (muldiv_busy) busy_cnt++;
        chk("add_during_busy_valid", W'(mem_valid), W'(1));
        chk("add_during_busy_result", mem_alu_result, 32'd7);
        issue_alu(ALU_MFHI, 32'd0, 32'd0);
        #1;
        stall_cnt = 0;
        bubble_cnt = 0;
        while (ex_stall && stall_cnt < 40) begin
            stall_cnt++;
            tick();
            if (!mem_valid) bubble_cnt++;
            if (muldiv_busy) busy_cnt++;
        end
        chk("mfhi_stall_cycles", W'(stall_cnt), W'(31));
        chk("mfhi_bubbles", W'(bubble_cnt), W'(31));
        chk("multu_busy_cycles", W'(busy_cnt), W'(32));
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        tick();
        chk("mfhi_valid", W'(mem_valid), W'(1));
        chk("mfhi_result", mem_alu_result, 32'h00000001);

        // DIVU 100/7
        issue_md(MD_DIVU, 32'd100, 32'd7);
        tick();
        idle_inputs();
        wait_idle(n);
        chk("divu_latency", W'(n), W'(32));
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // DIVU by zero, read back through MFLO
        issue_md(MD_DIVU, 32'd5, 32'd0);
        tick();
        idle_inputs();
        wait_idle(n);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 32'd5);
        issue_alu(ALU_MFLO, 32'd0, 32'd0);
        tick();
        chk("mflo_result", mem_alu_result, 32'hFFFFFFFF);

        // Reset in the middle of a DIVU
        issue_md(MD_DIVU, 32'd100, 32'd7);
        tick();
        issue_md(MD_MULTU, 32'd1, 32'd1);
        #1;
        chk("md_while_busy_stall", W'(ex_stall), W'(1));
        issue_alu(ALU_ADD, 32'd8, 32'd1);
        repeat (10) tick();
        chk("pre_reset_busy", W'(muldiv_busy), W'(1));
        chk("pre_reset_valid", W'(mem_valid), W'(1));
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", W'(muldiv_busy), '0);
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        chk("midrst_valid", W'(mem_valid), '0);
        #1 reset = 1'b1;
        issue_md(MD_MULTU, 32'h12345678, 32'h10);
        tick();
        chk("post_rst_start", W'(muldiv_busy), W'(1));
        idle_inputs();
        wait_idle(n);
        chk("post_rst_latency", W'(n), W'(32));
        chk("post_rst_hi", hi, 32'h00000001);
        chk("post_rst_lo", lo, 32'h23456780);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
